vm_credit_ledger: RTL and testbench
===================================

Name: vm_credit_ledger

Overview:
- Holds the customer's credit for the vending machine and drives `current_total` into the coin-return timer stage.
- Adds inserted coins and dispenses items against credit and per-item stock.
- Executes coin returns requested by the timer stage (its `o_return_coin`), deducting each returned coin from credit.
- All outputs are registered.

Parameters:
- NUM_COINS, 3, coin slots; index 0/1/2 = 100/500/1000
- NUM_ITEMS, 4, item slots; index 0..3 priced 400/500/1000/2000
- TOTAL_BITS, 31, width of credit register
- MAX_TOTAL, 100000, credit ceiling; coin batches that would exceed it are rejected
- STOCK_INIT, 5, initial stock per item (8-bit counters)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_input_coin  in  NUM_COINS  coins inserted this cycle, any combination
- i_select_item  in  NUM_ITEMS  item select buttons, level
- i_return_req  in  NUM_COINS  one-hot coin-return request from the timer stage
- current_total  out  TOTAL_BITS  registered credit
- o_available_item  out  NUM_ITEMS  bit k = price[k] <= current_total and stock[k] > 0
- o_output_item  out  NUM_ITEMS  one-cycle one-hot vend pulse
- o_return_coin  out  NUM_COINS  one-cycle one-hot coin-dispensed pulse
- o_coin_reject  out  1  one-cycle pulse: inserted coins refused and physically returned

Behaviour:
- Reset (async, reset_n=0):
  - current_total=0; o_output_item=0; o_return_coin=0; o_coin_reject=0.
  - All stock counters=STOCK_INIT; select-edge history cleared.
  - Release takes effect on the next clk edge.
- o_available_item: combinational from registered current_total and stock; reset value = 0 because total=0.
- Select edge detect:
  - vend_req = i_select_item & ~sel_q, where sel_q is the previous-cycle i_select_item.
  - Holding a button vends once; re-vending requires release and re-press.
- Vend decision, per clk edge:
  - Choose the lowest-index bit of vend_req whose o_available_item bit is set (evaluated on the registered total).
  - If one is chosen: o_output_item=that one-hot for exactly 1 cycle, its stock decrements, and price is deducted.
  - Unavailable requests are dropped silently; there is no retry.
- Coin add:
  - coin_sum = sum of values of all set i_input_coin bits; 0..1600 in one cycle.
  - If total + coin_sum - deductions > MAX_TOTAL: coin_sum is not added and o_coin_reject=1 for 1 cycle.
- Return:
  - i_return_req is honoured only if exactly one bit is set and its value <= total - vend price this cycle.
  - Then the value is deducted and o_return_coin mirrors the request for 1 cycle; otherwise it is ignored, with o_return_coin=0.
- Same-cycle ordering:
  - next_total = total - vend_price - return_value + accepted coin_sum.
  - Vend is checked first, then return against the remainder, then coin accept.
  - The result never underflows; all arithmetic is done at TOTAL_BITS+1 bits.
- Latency: every effect appears on current_total and the pulses one clk after the input is sampled.
- Stock: a counter at 0 masks the item permanently until reset; counters never wrap.
- Reset mid-vend or mid-return: pulses clear immediately and credit is lost; this is intended.

Test Plan:
- Reset mid-run:
  - Insert 1000, assert reset_n=0 asynchronously between edges.
  - Required: current_total=0 and all pulses 0 before the next edge; stock back to 5.
- Coin add and availability:
  - Insert 500+100 in one cycle, then 1000.
  - Required: current_total=600 then 1600; o_available_item=0011 after 600, 0111 after 1600.
- Vend with held select:
  - Total 1600, hold select[2] for 5 cycles.
  - Required: one o_output_item=0100 pulse; total=600; stock[2]=4.
- Return sequence:
  - Total 600; the timer stage requests 010 then 001.
  - Required: o_return_coin=010 then 001; total 100 then 0.
  - A further 001 request at total 0 is ignored.
- Simultaneous events:
  - Total 1000; in one cycle press item1 (500), request return 100, insert 1000.
  - Required: vend 0010, return 001, total=1400.
- Ceiling and stock exhaustion:
  - Total 99500, insert 1000: o_coin_reject=1 and total unchanged.
  - Vend item0 5 times from ample credit: 6th press gives no pulse and o_available_item[0]=0.

Source files
------------

// File: rtl/vm_credit_ledger_if.sv
// Bus between the vending-machine credit ledger and its neighbours:
// coin/select/return requests in, credit and one-cycle pulses out.
interface vm_credit_ledger_if #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31
);
  logic [NUM_COINS-1:0]  i_input_coin;
  logic [NUM_ITEMS-1:0]  i_select_item;
  logic [NUM_COINS-1:0]  i_return_req;
  logic [TOTAL_BITS-1:0] current_total;
  logic [NUM_ITEMS-1:0]  o_available_item;
  logic [NUM_ITEMS-1:0]  o_output_item;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic                  o_coin_reject;

  modport master (
    output i_input_coin, i_select_item, i_return_req,
    input  current_total, o_available_item, o_output_item, o_return_coin, o_coin_reject
  );

  modport slave (
    input  i_input_coin, i_select_item, i_return_req,
    output current_total, o_available_item, o_output_item, o_return_coin, o_coin_reject
  );
endinterface

// File: rtl/vm_credit_ledger.sv
// Credit ledger for the vending machine: accumulates coins, vends against
// credit and stock, and pays out coin returns requested by the timer stage.
module vm_credit_ledger #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int MAX_TOTAL  = 100000,
  parameter int STOCK_INIT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  vm_credit_ledger_if.slave bus
);

  localparam int W = TOTAL_BITS + 1;

  function automatic logic [W-1:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = W'(100);
      1:       coin_value = W'(500);
      default: coin_value = W'(1000);
    endcase
  endfunction

  function automatic logic [W-1:0] item_price(input int idx);
    case (idx)
      0:       item_price = W'(400);
      1:       item_price = W'(500);
      2:       item_price = W'(1000);
      default: item_price = W'(2000);
    endcase
  endfunction

  logic [7:0]           stock_q [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sel_q;
  logic [NUM_ITEMS-1:0] avail;
  logic [NUM_ITEMS-1:0] vend_req;
  logic [NUM_ITEMS-1:0] vend_hot;
  logic                 vend_found;
  logic [W-1:0]         total_ext;
  logic [W-1:0]         vend_price;
  logic [W-1:0]         rem_after_vend;
  logic [W-1:0]         ret_val;
  logic                 ret_ok;
  logic [W-1:0]         rem_after_ret;
  logic [W-1:0]         coin_sum;
  logic                 coin_reject;
  logic [W-1:0]         next_total;

  assign total_ext = {1'b0, bus.current_total};
  assign vend_req  = bus.i_select_item & ~sel_q;

  always_comb begin
    avail = '0;
    for (int k = 0; k < NUM_ITEMS; k++)
      avail[k] = (item_price(k) <= total_ext) && (stock_q[k] != 8'd0);
  end

  assign bus.o_available_item = avail;

  // Vend first, then the return against what is left, then coin acceptance.
  always_comb begin
    vend_hot   = '0;
    vend_found = 1'b0;
    vend_price = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (!vend_found && vend_req[k] && avail[k]) begin
        vend_found  = 1'b1;
        vend_hot[k] = 1'b1;
        vend_price  = item_price(k);
      end
    end
    rem_after_vend = total_ext - vend_price;

    ret_val = '0;
    for (int c = 0; c < NUM_COINS; c++)
      if (bus.i_return_req[c]) ret_val = coin_value(c);
    ret_ok        = $onehot(bus.i_return_req) && (ret_val <= rem_after_vend);
    rem_after_ret = ret_ok ? rem_after_vend - ret_val : rem_after_vend;

    coin_sum = '0;
    for (int c = 0; c < NUM_COINS; c++)
      if (bus.i_input_coin[c]) coin_sum = coin_sum + coin_value(c);
    coin_reject = (coin_sum != '0) && ((rem_after_ret + coin_sum) > W'(MAX_TOTAL));
    next_total  = coin_reject ? rem_after_ret : rem_after_ret + coin_sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.current_total <= '0;
      bus.o_output_item <= '0;
      bus.o_return_coin <= '0;
      bus.o_coin_reject <= 1'b0;
      sel_q             <= '0;
      for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= 8'(STOCK_INIT);
    end else begin
      bus.current_total <= next_total[TOTAL_BITS-1:0];
      bus.o_output_item <= vend_hot;
      bus.o_return_coin <= ret_ok ? bus.i_return_req : '0;
      bus.o_coin_reject <= coin_reject;
      sel_q             <= bus.i_select_item;
      // A vended item was available, so its counter is nonzero here.
      for (int k = 0; k < NUM_ITEMS; k++)
        if (vend_hot[k]) stock_q[k] <= stock_q[k] - 8'd1;
    end
  end

endmodule

// File: tb/tb_vm_credit_ledger.sv
// Directed bench for vm_credit_ledger: hand-computed credit, pulse and
// availability values for reset, vend, return, ceiling and stock cases.
module tb_vm_credit_ledger;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  vm_credit_ledger_if #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31)) bus ();

  vm_credit_ledger #(
    .NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31), .MAX_TOTAL(100000), .STOCK_INIT(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Coins and return requests are single-cycle; the select level persists.
  task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel,
                               input logic [2:0] ret);
    @(negedge clk);
    bus.i_input_coin  = coin;
    bus.i_select_item = sel;
    bus.i_return_req  = ret;
    @(posedge clk);
    #1;
    bus.i_input_coin = 3'b000;
    bus.i_return_req = 3'b000;
  endtask

  task automatic checkPulses(input string tag, input logic [3:0] item,
                             input logic [2:0] ret, input logic rej);
    checkOutput({tag, " item"}, 32'(bus.o_output_item), 32'(item));
    checkOutput({tag, " ret"}, 32'(bus.o_return_coin), 32'(ret));
    checkOutput({tag, " rej"}, 32'(bus.o_coin_reject), 32'(rej));
  endtask

  initial begin
    bus.i_input_coin  = 3'b000;
    bus.i_select_item = 4'b0000;
    bus.i_return_req  = 3'b000;
    #12;
    checkOutput("reset total", 32'(bus.current_total), 32'd0);
    checkOutput("reset avail", 32'(bus.o_available_item), 32'd0);
    checkPulses("reset", 4'b0000, 3'b000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted between edges after some activity.
    applyStimulus(3'b100, 4'b0000, 3'b000);
    checkOutput("pre-reset total", 32'(bus.current_total), 32'd1000);
    applyStimulus(3'b000, 4'b0001, 3'b000);
    checkOutput("pre-reset vend", 32'(bus.o_output_item), 32'b0001);
    checkOutput("pre-reset stock0", 32'(dut.stock_q[0]), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async total", 32'(bus.current_total), 32'd0);
    checkPulses("async", 4'b0000, 3'b000, 1'b0);
    checkOutput("async stock0", 32'(dut.stock_q[0]), 32'd5);
    bus.i_select_item = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(3'b011, 4'b0000, 3'b000);
    checkOutput("add 600", 32'(bus.current_total), 32'd600);
    checkOutput("avail 600", 32'(bus.o_available_item), 32'b0011);
    applyStimulus(3'b100, 4'b0000, 3'b000);
    checkOutput("add 1600", 32'(bus.current_total), 32'd1600);
    checkOutput("avail 1600", 32'(bus.o_available_item), 32'b0111);

    applyStimulus(3'b000, 4'b0100, 3'b000);
    checkPulses("hold vend", 4'b0100, 3'b000, 1'b0);
    checkOutput("hold total", 32'(bus.current_total), 32'd600);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b000, 4'b0100, 3'b000);
      checkOutput("held no vend", 32'(bus.o_output_item), 32'd0);
    end
    checkOutput("held total", 32'(bus.current_total), 32'd600);
    checkOutput("stock2", 32'(dut.stock_q[2]), 32'd4);
    applyStimulus(3'b000, 4'b0000, 3'b000);

    applyStimulus(3'b000, 4'b0000, 3'b010);
    checkPulses("ret 500", 4'b0000, 3'b010, 1'b0);
    checkOutput("ret 500 total", 32'(bus.current_total), 32'd100);
    applyStimulus(3'b000, 4'b0000, 3'b001);
    checkPulses("ret 100", 4'b0000, 3'b001, 1'b0);
    checkOutput("ret 100 total", 32'(bus.current_total), 32'd0);
    applyStimulus(3'b000, 4'b0000, 3'b001);
    checkPulses("ret at 0", 4'b0000, 3'b000, 1'b0);
    checkOutput("ret at 0 total", 32'(bus.current_total), 32'd0);

    applyStimulus(3'b100, 4'b0000, 3'b000);
    checkOutput("refill 1000", 32'(bus.current_total), 32'd1000);
    applyStimulus(3'b100, 4'b0010, 3'b001);
    checkPulses("simul", 4'b0010, 3'b001, 1'b0);
    checkOutput("simul total", 32'(bus.current_total), 32'd1400);
    applyStimulus(3'b000, 4'b0000, 3'b000);

    // 1400 + 61*1600 + 500 = 99500
    for (int i = 0; i < 61; i++) applyStimulus(3'b111, 4'b0000, 3'b000);
    applyStimulus(3'b010, 4'b0000, 3'b000);
    checkOutput("fill 99500", 32'(bus.current_total), 32'd99500);
    applyStimulus(3'b100, 4'b0000, 3'b000);
    checkPulses("ceiling rej", 4'b0000, 3'b000, 1'b1);
    checkOutput("ceiling total", 32'(bus.current_total), 32'd99500);
    applyStimulus(3'b010, 4'b0000, 3'b000);
    checkPulses("exact max", 4'b0000, 3'b000, 1'b0);
    checkOutput("exact max total", 32'(bus.current_total), 32'd100000);
    applyStimulus(3'b001, 4'b0000, 3'b000);
    checkOutput("over max rej", 32'(bus.o_coin_reject), 32'd1);
    checkOutput("over max total", 32'(bus.current_total), 32'd100000);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b000, 4'b0001, 3'b000);
      checkOutput("drain vend", 32'(bus.o_output_item), 32'b0001);
      applyStimulus(3'b000, 4'b0000, 3'b000);
    end
    checkOutput("drain total", 32'(bus.current_total), 32'd98000);
    checkOutput("drain avail", 32'(bus.o_available_item), 32'b1110);
    applyStimulus(3'b000, 4'b0001, 3'b000);
    checkOutput("sixth press", 32'(bus.o_output_item), 32'd0);
    checkOutput("sixth total", 32'(bus.current_total), 32'd98000);
    applyStimulus(3'b000, 4'b0000, 3'b000);

    applyStimulus(3'b000, 4'b0000, 3'b011);
    checkPulses("multi ret", 4'b0000, 3'b000, 1'b0);
    checkOutput("multi ret total", 32'(bus.current_total), 32'd98000);
    applyStimulus(3'b000, 4'b0110, 3'b000);
    checkOutput("priority vend", 32'(bus.o_output_item), 32'b0010);
    checkOutput("priority total", 32'(bus.current_total), 32'd97500);
    applyStimulus(3'b000, 4'b0000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
